fp_compare_pipe: RTL
====================

// Module: fp_compare_pipe
// PURPOSE
//  Parametrised, pipelined FP compare / min / max unit with valid-ready handshake, IEEE 754 binary format.
//  Generic width, selectable latency, tag passthrough and sticky exception flags.
//  Sits in the FPU issue path; backpressure comes from the result bus.
// PARAMETERS
//  FPWID  48  total operand width (sign + EXPW + fraction)
//  EXPW   11  exponent width; fraction width FW = FPWID-1-EXPW
//  LAT    2   register stages, input to result (legal 1..4)
//  TAGW   8   width of the tag carried with each operation
// PORTS
//  clk        in   1      clock
//  rst        in   1      synchronous reset, active high
//  in_valid   in   1      operation presented
//  in_ready   out  1      unit accepts operation this cycle
//  op         in   2      0=CMP 1=MIN 2=MAX 3=reserved (executes as CMP)
//  a, b       in   FPWID  operands
//  tag        in   TAGW   returned unchanged with the result
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  o          out  16     compare bit vector (see BEHAVIOUR)
//  res        out  FPWID  MIN/MAX result; CMP returns 0
//  out_tag    out  TAGW   tag of the result
//  nan        out  1      either operand NaN, or both operands infinite
//  snan       out  1      either operand signalling NaN (fraction MSB = 0)
//  inf        out  1      both operands infinite
//  flg_clr    in   1      clear sticky flags
//  flg_sticky out  3      {nan,snan,inf} OR-accumulated over accepted results
// BEHAVIOUR
//  - Reset: all stage valids, out_valid, o, res, out_tag, nan/snan/inf, flg_sticky = 0; in-flight ops are dropped.
//  - Global advance: ce = !out_valid | out_ready; in_ready = ce. No bubble collapse; the whole pipe stalls together.
//  - Accept when in_valid & in_ready; the result appears exactly LAT cycles later if never stalled.
//  - Order is strictly preserved. Stage outputs hold stable while stalled.
//  - Decode: zero = exp==0 & frac==0; inf = exp all-ones & frac==0; NaN = exp all-ones & frac!=0.
//  - unord = nanA|nanB; eq = !unord & (both zero | a==b); ne = !(both zero | a==b).
//  - mlt = {expA,fracA} < {expB,fracB} | (infB & ~infA); mgt symmetric.
//  - lt = signs differ ? sA & !(both zero) : (sA ? mgt : mlt).
//  - o bit map: [0]=eq, [1]=lt&!unord, [2]=(lt|eq)&!unord, [3]=mlt, [4]=unord, [7:5]=0.
//  - o bit map: [8]=ne, [9]=!lt&!unord, [10]=!(lt|eq)&!unord, [11]=!mlt, [12]=!unord, [15:13]=0.
//  - MIN/MAX rules:
//    - one NaN operand -> the other operand.
//    - both NaN -> canonical qNaN (sign 0, exp all-ones, frac MSB 1, rest 0).
//    - -0 orders below +0.
//    - equal values -> a.
//  - o is computed for all ops; res = 0 for CMP and reserved op.
//  - Sticky: on each cycle with out_valid & out_ready, OR {nan,snan,inf} into flg_sticky.
//    - flg_clr in the same cycle clears the old value but the new event is still set (event wins).
// STRUCTURE
//  - Package fpCmpPkg: op enum, o bit-index localparams, function for canonical qNaN of any FPWID/EXPW.
//  - Sub-module fp_decomp_gen #(FPWID,EXPW): combinational sign/exp/frac/zero/inf/nan/snan decode, one per operand.
//  - Stage 1 registers decode; last stage registers o/res/flags. LAT>2 adds pass-through delay stages.
// TESTING (FPWID=32, EXPW=8)
//  1. CMP a=3F800000 b=40000000 -> o=110E, nan=0, after exactly LAT cycles.
//  2. CMP a=80000000 b=00000000 -> o=1A05 (eq, -0 == +0).
//  3. CMP a=7FC00000 b=3F800000 -> o=0910, nan=1, snan=0.
//     a=7F800001 -> snan=1, flg_sticky[1]=1 until flg_clr.
//  4. MIN qNaN,40000000 -> 40000000. MIN 80000000,00000000 -> 80000000.
//     MAX same pair -> 00000000. MIN qNaN,qNaN -> 7FC00000.
//  5. Back-to-back 4 ops (tags 1..4), out_ready=0 for 3 cycles:
//     in_ready=0 while stalled; outputs held stable; all 4 delivered in tag order, none lost or duplicated.
//  6. rst asserted with 2 ops in flight -> next cycle out_valid=0, flg_sticky=0; no stale result after release.
//     Also flg_clr coincident with a NaN result -> flg_sticky[2]=1.

Source files
------------

// File: rtl/fp_compare_pipe_pkg.sv
// Shared types for the FP compare/min/max pipe: opcode enum, result-vector bit positions
// and a canonical quiet-NaN builder usable for any operand/exponent width.
package fp_compare_pipe_pkg;

    typedef enum logic [1:0] {
        OP_CMP  = 2'd0,
        OP_MIN  = 2'd1,
        OP_MAX  = 2'd2,
        OP_RSVD = 2'd3
    } fp_op_e;

    localparam int O_EQ    = 0;
    localparam int O_LT    = 1;
    localparam int O_LE    = 2;
    localparam int O_MLT   = 3;
    localparam int O_UNORD = 4;
    localparam int O_NE    = 8;
    localparam int O_GE    = 9;
    localparam int O_GT    = 10;
    localparam int O_MGE   = 11;
    localparam int O_ORD   = 12;

    localparam int QNAN_MAXW = 128;

    // Sign 0, exponent all ones, fraction MSB set; caller keeps the low fpwid bits.
    function automatic logic [QNAN_MAXW-1:0] canon_qnan(input int fpwid, input int expw);
        logic [QNAN_MAXW-1:0] v;
        v = '0;
        for (int i = 0; i < QNAN_MAXW; i++) begin
            if (i >= fpwid - 2 - expw && i <= fpwid - 2)
                v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/fp_compare_pipe_decomp.sv
// Combinational field split and class decode of one IEEE-754 operand; no latency,
// no handshake of its own.
module fp_decomp_gen #(
    parameter int FPWID = 48,
    parameter int EXPW  = 11
) (
    input  logic [FPWID-1:0]      x,
    output logic                  sgn,
    output logic [EXPW-1:0]       expo,
    output logic [FPWID-EXPW-2:0] frac,
    output logic                  zero,
    output logic                  inf,
    output logic                  nan,
    output logic                  snan
);
    localparam int FW = FPWID - 1 - EXPW;

    logic exp_ones;
    logic frac_nz;

    assign sgn      = x[FPWID-1];
    assign expo     = x[FPWID-2 -: EXPW];
    assign frac     = x[FW-1:0];
    assign exp_ones = &expo;
    assign frac_nz  = |frac;
    assign zero     = ~(|expo) & ~frac_nz;
    assign inf      = exp_ones & ~frac_nz;
    assign nan      = exp_ones & frac_nz;
    assign snan     = nan & ~frac[FW-1];

endmodule

// File: rtl/fp_compare_pipe.sv
// Pipelined FP compare/min/max with tag passthrough and sticky flags; LAT cycles input to result.
// Whole pipe advances together when the result slot is empty or being taken (in_ready = ce).
module fp_compare_pipe
    import fp_compare_pipe_pkg::*;
#(
    parameter int FPWID = 48,
    parameter int EXPW  = 11,
    parameter int LAT   = 2,
    parameter int TAGW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [FPWID-1:0] a,
    input  logic [FPWID-1:0] b,
    input  logic [TAGW-1:0]  tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      o,
    output logic [FPWID-1:0] res,
    output logic [TAGW-1:0]  out_tag,
    output logic             nan,
    output logic             snan,
    output logic             inf,
    input  logic             flg_clr,
    output logic [2:0]       flg_sticky
);
    localparam int FW   = FPWID - 1 - EXPW;
    localparam int NOUT = (LAT > 1) ? LAT - 1 : 1;
    localparam logic [QNAN_MAXW-1:0] QNAN_W = canon_qnan(FPWID, EXPW);
    localparam logic [FPWID-1:0]     QNAN   = QNAN_W[FPWID-1:0];

    typedef struct packed {
        logic [TAGW-1:0]  tag;
        logic [1:0]       op;
        logic [FPWID-2:0] ma, mb;
        logic             sa, sb, za, zb, ia, ib, na, nb, sna, snb;
    } dec_t;

    typedef struct packed {
        logic [TAGW-1:0]  tag;
        logic [15:0]      o;
        logic [FPWID-1:0] res;
        logic             nan, snan, inf;
    } rslt_t;

    logic            ce;
    logic [EXPW-1:0] ea, eb;
    logic [FW-1:0]   fa, fb;
    dec_t            dec_in, cur;
    logic            cur_vld;
    rslt_t           rslt;
    rslt_t           pipe [NOUT];
    logic [NOUT-1:0] vld;
    logic [2:0]      flg_evt;

    assign ce       = ~out_valid | out_ready;
    assign in_ready = ce;

    fp_decomp_gen #(.FPWID(FPWID), .EXPW(EXPW)) u_dec_a (
        .x(a), .sgn(dec_in.sa), .expo(ea), .frac(fa),
        .zero(dec_in.za), .inf(dec_in.ia), .nan(dec_in.na), .snan(dec_in.sna)
    );
    fp_decomp_gen #(.FPWID(FPWID), .EXPW(EXPW)) u_dec_b (
        .x(b), .sgn(dec_in.sb), .expo(eb), .frac(fb),
        .zero(dec_in.zb), .inf(dec_in.ib), .nan(dec_in.nb), .snan(dec_in.snb)
    );

    assign dec_in.tag = tag;
    assign dec_in.op  = op;
    assign dec_in.ma  = {ea, fa};
    assign dec_in.mb  = {eb, fb};

    generate
        if (LAT == 1) begin : g_comb_in
            assign cur     = dec_in;
            assign cur_vld = in_valid;
        end else begin : g_stage1
            dec_t s1;
            logic s1_vld;
            always_ff @(posedge clk) begin
                if (rst) begin
                    s1     <= '0;
                    s1_vld <= 1'b0;
                end else if (ce) begin
                    s1     <= dec_in;
                    s1_vld <= in_valid;
                end
            end
            assign cur     = s1;
            assign cur_vld = s1_vld;
        end
    endgenerate

    always_comb begin
        logic both_zero, same, unord, eq, lt, mlt, mgt, a_below, b_below;
        logic [FPWID-1:0] av, bv;
        av        = {cur.sa, cur.ma};
        bv        = {cur.sb, cur.mb};
        both_zero = cur.za & cur.zb;
        same      = (av == bv);
        unord     = cur.na | cur.nb;
        eq        = ~unord & (both_zero | same);
        mlt       = (cur.ma < cur.mb) | (cur.ib & ~cur.ia);
        mgt       = (cur.ma > cur.mb) | (cur.ia & ~cur.ib);
        lt        = (cur.sa != cur.sb) ? (cur.sa & ~both_zero) : (cur.sa ? mgt : mlt);
        // Signed zeros compare equal but MIN/MAX still order -0 below +0.
        a_below   = lt | (both_zero & cur.sa & ~cur.sb);
        b_below   = (~lt & ~both_zero & ~same) | (both_zero & cur.sb & ~cur.sa);

        rslt            = '0;
        rslt.tag        = cur.tag;
        rslt.o[O_EQ]    = eq;
        rslt.o[O_LT]    = lt & ~unord;
        rslt.o[O_LE]    = (lt | eq) & ~unord;
        rslt.o[O_MLT]   = mlt;
        rslt.o[O_UNORD] = unord;
        rslt.o[O_NE]    = ~(both_zero | same);
        rslt.o[O_GE]    = ~lt & ~unord;
        rslt.o[O_GT]    = ~(lt | eq) & ~unord;
        rslt.o[O_MGE]   = ~mlt;
        rslt.o[O_ORD]   = ~unord;
        rslt.nan        = unord | (cur.ia & cur.ib);
        rslt.snan       = cur.sna | cur.snb;
        rslt.inf        = cur.ia & cur.ib;

        case (fp_op_e'(cur.op))
            OP_MIN, OP_MAX: begin
                if (cur.na & cur.nb)
                    rslt.res = QNAN;
                else if (cur.na)
                    rslt.res = bv;
                else if (cur.nb)
                    rslt.res = av;
                else if (fp_op_e'(cur.op) == OP_MIN)
                    rslt.res = b_below ? bv : av;
                else
                    rslt.res = a_below ? bv : av;
            end
            default: rslt.res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            for (int k = 0; k < NOUT; k++)
                pipe[k] <= '0;
        end else if (ce) begin
            vld[0]  <= cur_vld;
            pipe[0] <= rslt;
            for (int k = 1; k < NOUT; k++) begin
                vld[k]  <= vld[k-1];
                pipe[k] <= pipe[k-1];
            end
        end
    end

    assign out_valid = vld[NOUT-1];
    assign o         = pipe[NOUT-1].o;
    assign res       = pipe[NOUT-1].res;
    assign out_tag   = pipe[NOUT-1].tag;
    assign nan       = pipe[NOUT-1].nan;
    assign snan      = pipe[NOUT-1].snan;
    assign inf       = pipe[NOUT-1].inf;

    // A clear in the same cycle as a delivered event keeps the new event.
    assign flg_evt = (out_valid & out_ready) ? {nan, snan, inf} : 3'b000;

    always_ff @(posedge clk) begin
        if (rst)
            flg_sticky <= 3'b000;
        else
            flg_sticky <= (flg_clr ? 3'b000 : flg_sticky) | flg_evt;
    end

endmodule
